// File: rtl/div_unit_if.sv
// Start/busy/done handshake and operand/result bus of the iterative divider.
interface div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Result;

  modport master (output start, op, A, B, input busy, done, Result);
  modport slave  (input start, op, A, B, output busy, done, Result);
endinterface

// File: rtl/div_unit.sv
// RV32M DIV/DIVU/REM/REMU unit: radix-2 restoring divider, one quotient bit per cycle.
// Divide-by-zero and signed overflow finish at the accept edge without iterating.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic       CLK,
  input  logic       RST,
  div_unit_if.slave  bus
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [1:0]       op_q, op_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;

  logic [WIDTH:0]   shift_c;
  logic             ge_c;
  logic [WIDTH-1:0] rem_step_c, quo_step_c;
  logic             signed_c, b_zero_c, ovf_c;
  logic [WIDTH-1:0] a_mag_c, b_mag_c;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
      op_q     <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      result_q <= result_d;
      op_q     <= op_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    result_d = result_q;
    op_d     = op_q;
    negq_d   = negq_q;
    negr_d   = negr_q;

    // One restoring step: quo_q shifts the dividend out MSB-first and the quotient in LSB-first.
    shift_c    = {rem_q, quo_q[WIDTH-1]};
    ge_c       = shift_c >= {1'b0, dvs_q};
    rem_step_c = ge_c ? WIDTH'(shift_c - {1'b0, dvs_q}) : shift_c[WIDTH-1:0];
    quo_step_c = {quo_q[WIDTH-2:0], ge_c};

    signed_c = ~bus.op[0];
    b_zero_c = (bus.B == '0);
    ovf_c    = signed_c && (bus.A == MIN_NEG) && (bus.B == '1);
    a_mag_c  = (signed_c && bus.A[WIDTH-1]) ? (~bus.A + WIDTH'(1)) : bus.A;
    b_mag_c  = (signed_c && bus.B[WIDTH-1]) ? (~bus.B + WIDTH'(1)) : bus.B;

    case (state_q)
      CALC: begin
        rem_d = rem_step_c;
        quo_d = quo_step_c;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          case (op_q)
            2'b00:   result_d = negq_q ? (~quo_step_c + WIDTH'(1)) : quo_step_c;
            2'b01:   result_d = quo_step_c;
            2'b10:   result_d = negr_q ? (~rem_step_c + WIDTH'(1)) : rem_step_c;
            default: result_d = rem_step_c;
          endcase
        end
      end
      default: begin
        state_d = IDLE;
        if (bus.start) begin
          op_d = bus.op;
          if (b_zero_c) begin
            state_d  = DONE;
            result_d = bus.op[1] ? bus.A : '1;
          end else if (ovf_c) begin
            state_d  = DONE;
            result_d = bus.op[1] ? '0 : MIN_NEG;
          end else begin
            state_d = CALC;
            rem_d   = '0;
            cnt_d   = '0;
            quo_d   = a_mag_c;
            dvs_d   = b_mag_c;
            negq_d  = bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
            negr_d  = bus.A[WIDTH-1];
          end
        end
      end
    endcase
  end

  assign bus.busy   = (state_q == CALC);
  assign bus.done   = (state_q == DONE);
  assign bus.Result = result_q;
endmodule
